// File: rtl/vx_gpr_ram_mp_if.sv
// Register-file bus: one masked write port, NUM_RPORTS read ports, clear/ready.
// The operand/writeback side uses master; the RAM uses slave.
interface vx_gpr_ram_mp_if #(
  parameter int DATAW      = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_RPORTS = 2,
  parameter int WRENW      = 1,
  parameter int ADDRW      = $clog2(DEPTH)
);
  logic                          clear;
  logic                          ready;
  logic                          wren;
  logic [WRENW-1:0]              wmask;
  logic [ADDRW-1:0]              waddr;
  logic [DATAW-1:0]              wdata;
  logic [NUM_RPORTS-1:0]         rden;
  logic [NUM_RPORTS*ADDRW-1:0]   raddr;
  logic [NUM_RPORTS-1:0]         rvalid;
  logic [NUM_RPORTS*DATAW-1:0]   rdata;

  modport master (
    output clear, wren, wmask, waddr, wdata, rden, raddr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  clear, wren, wmask, waddr, wdata, rden, raddr,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/vx_gpr_ram_mp.sv
// Multi-read-port GPR RAM: masked write, registered reads with optional
// write-first bypass, and a zeroing sweep after reset or on clear.
module vx_gpr_ram_mp #(
  parameter int DATAW      = 32,
  parameter int DEPTH      = 32,
  parameter int NUM_RPORTS = 2,
  parameter int WRENW      = 1,
  parameter int BYPASS     = 1,
  parameter int ADDRW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,   // asynchronous, active low
  vx_gpr_ram_mp_if.slave     bus
);
  localparam int LANEW = DATAW / WRENW;

  typedef enum logic {INIT, RUN} state_e;

  state_e                                 state_q;
  logic [ADDRW-1:0]                       cnt_q;
  logic [NUM_RPORTS-1:0]                  rvalid_q;
  logic [NUM_RPORTS-1:0][DATAW-1:0]       rdata_q;
  logic [DATAW-1:0]                       mem [DEPTH];

  logic                                   acc_ok;   // accesses honoured this cycle
  logic                                   wr_fire;
  logic [DATAW-1:0]                       wr_merged;
  logic [NUM_RPORTS-1:0]                  byp_hit;

  assign acc_ok    = (state_q == RUN) && !bus.clear;
  assign wr_fire   = acc_ok && bus.wren;
  assign bus.ready = (state_q == RUN);
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

  // Merge masked lanes of wdata over the current entry; used for both write and bypass.
  always_comb begin
    wr_merged = mem[bus.waddr];
    for (int j = 0; j < WRENW; j++) begin
      if (bus.wmask[j]) wr_merged[j*LANEW +: LANEW] = bus.wdata[j*LANEW +: LANEW];
    end
  end

  // Per-port forwarding select: write and read hit the same entry this cycle.
  always_comb begin
    byp_hit = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      byp_hit[i] = (BYPASS != 0) && wr_fire && (bus.waddr == bus.raddr[i*ADDRW +: ADDRW]);
    end
  end

  // Sweep sequencer: INIT walks cnt over every entry, RUN waits for clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (bus.clear) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= (cnt_q == ADDRW'(DEPTH-1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == ADDRW'(DEPTH-1)) state_q <= RUN;
          end
        end
        default: begin
          if (bus.clear) begin
            state_q <= INIT;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Storage: zero fill during the sweep, masked write in RUN; no reset on the array.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[cnt_q] <= '0;
    else if (wr_fire)    mem[bus.waddr] <= wr_merged;
  end

  // Registered read ports; rdata holds when a port is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_RPORTS; i++) begin
        rvalid_q[i] <= acc_ok && bus.rden[i];
        if (acc_ok && bus.rden[i]) begin
          rdata_q[i] <= byp_hit[i] ? wr_merged : mem[bus.raddr[i*ADDRW +: ADDRW]];
        end
      end
    end
  end
endmodule

// File: tb/tb_vx_gpr_ram_mp.sv
// Bench for vx_gpr_ram_mp: a BYPASS=1 and a BYPASS=0 instance driven with the
// same stimulus and compared against an array-based reference model.
module tb_vx_gpr_ram_mp;
  localparam int DW = 32, DP = 32, NP = 3, WN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             clear = 1'b0;
  logic             wren = 1'b0;
  logic [WN-1:0]    wmask = '0;
  logic [4:0]       waddr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [NP-1:0]    rden = '0;
  logic [4:0]       ra [NP];

  vx_gpr_ram_mp_if #(.DATAW(DW), .DEPTH(DP), .NUM_RPORTS(NP), .WRENW(WN)) if_b ();
  vx_gpr_ram_mp_if #(.DATAW(DW), .DEPTH(DP), .NUM_RPORTS(NP), .WRENW(WN)) if_n ();

  assign if_b.clear = clear;  assign if_n.clear = clear;
  assign if_b.wren  = wren;   assign if_n.wren  = wren;
  assign if_b.wmask = wmask;  assign if_n.wmask = wmask;
  assign if_b.waddr = waddr;  assign if_n.waddr = waddr;
  assign if_b.wdata = wdata;  assign if_n.wdata = wdata;
  assign if_b.rden  = rden;   assign if_n.rden  = rden;
  assign if_b.raddr = {ra[2], ra[1], ra[0]};
  assign if_n.raddr = {ra[2], ra[1], ra[0]};

  vx_gpr_ram_mp #(.DATAW(DW), .DEPTH(DP), .NUM_RPORTS(NP), .WRENW(WN), .BYPASS(1))
    u_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
  vx_gpr_ram_mp #(.DATAW(DW), .DEPTH(DP), .NUM_RPORTS(NP), .WRENW(WN), .BYPASS(0))
    u_n (.clk(clk), .reset(rst_n), .bus(if_n.slave));

  // Reference model state
  logic [DW-1:0] m [DP];
  int            sweep_left;          // cycles until ready; 0 means RUN
  logic [DW-1:0] exp_b [NP];
  logic [DW-1:0] exp_n [NP];
  logic [NP-1:0] exp_rv;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sweep_left = DP;
    exp_rv = '0;
    for (int p = 0; p < NP; p++) begin exp_b[p] = '0; exp_n[p] = '0; end
    for (int a = 0; a < DP; a++) m[a] = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_edge();
    logic [DW-1:0] nv;
    if (sweep_left > 0) begin
      exp_rv = '0;
      sweep_left = clear ? DP : sweep_left - 1;
    end else if (clear) begin
      exp_rv = '0;
      sweep_left = DP;
      for (int a = 0; a < DP; a++) m[a] = '0;
    end else begin
      nv = m[waddr];
      for (int j = 0; j < WN; j++) if (wmask[j]) nv[j*8 +: 8] = wdata[j*8 +: 8];
      for (int p = 0; p < NP; p++) begin
        exp_rv[p] = rden[p];
        if (rden[p]) begin
          exp_n[p] = m[ra[p]];
          exp_b[p] = (wren && waddr == ra[p]) ? nv : m[ra[p]];
        end
      end
      if (wren) m[waddr] = nv;
    end
  endtask

  task automatic compare();
    chk("ready_b", {31'b0, if_b.ready}, {31'b0, sweep_left == 0});
    chk("ready_n", {31'b0, if_n.ready}, {31'b0, sweep_left == 0});
    chk("rvalid_b", {29'b0, if_b.rvalid}, {29'b0, exp_rv});
    chk("rvalid_n", {29'b0, if_n.rvalid}, {29'b0, exp_rv});
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rdata_b%0d", p), if_b.rdata[p*DW +: DW], exp_b[p]);
      chk($sformatf("rdata_n%0d", p), if_n.rdata[p*DW +: DW], exp_n[p]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle();
    clear = 1'b0; wren = 1'b0; wmask = '0; rden = '0;
  endtask

  // Asynchronous reset pulse between edges; outputs must drop without a clock.
  task automatic reset_pulse(input string tag);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_ready"},  {31'b0, if_b.ready}, 32'd0);
    chk({tag, "_rvalid"}, {29'b0, if_b.rvalid | if_n.rvalid}, 32'd0);
    chk({tag, "_rdata"},  if_b.rdata[31:0] | if_b.rdata[63:32] | if_b.rdata[95:64], 32'd0);
    #1 rst_n = 1'b1;
  endtask

  // Steps until ready, bounded; returns the number of edges taken.
  task automatic wait_ready(output int n);
    n = 0;
    while (!if_b.ready && n < DP + 8) begin step(); n++; end
  endtask

  task automatic read_all_zero(input string tag);
    idle();
    rden = '1;
    for (int a = 0; a < DP; a++) begin
      ra[0] = 5'(a); ra[1] = 5'((a + 1) % DP); ra[2] = 5'((a + 2) % DP);
      step();
      chk({tag, "_zero"}, if_b.rdata[31:0] | if_n.rdata[31:0], 32'd0);
    end
    idle();
  endtask

  typedef struct {
    logic          wren;
    logic [3:0]    wmask;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [4:0]    raddr1;
    logic [31:0]   exp_b;    // port-1 read data, bypass instance
    logic [31:0]   exp_n;    // port-1 read data, read-old instance
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 4'hF, 5'd5, 32'hAABBCCDD, 5'd5, 32'hAABBCCDD, 32'h00000000};
    vecs[1] = '{1'b1, 4'h5, 5'd5, 32'h11223344, 5'd5, 32'hAA22CC44, 32'hAABBCCDD};
    vecs[2] = '{1'b0, 4'h0, 5'd0, 32'h00000000, 5'd5, 32'hAA22CC44, 32'hAA22CC44};
    vecs[3] = '{1'b1, 4'hF, 5'd3, 32'hDEADBEEF, 5'd3, 32'hDEADBEEF, 32'h00000000};
    vecs[4] = '{1'b0, 4'h0, 5'd0, 32'h00000000, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 4'h0, 5'd9, 32'h12345678, 5'd9, 32'h00000000, 32'h00000000};
    vecs[6] = '{1'b0, 4'h0, 5'd0, 32'h00000000, 5'd9, 32'h00000000, 32'h00000000};

    for (int p = 0; p < NP; p++) ra[p] = 5'(p);
    model_reset();

    // Reset state, with accesses requested that the sweep must ignore.
    wren = 1'b1; wmask = 4'hF; waddr = 5'd3; wdata = 32'hFFFFFFFF; rden = '1;
    #12;
    compare();
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_len", n, DP);
    read_all_zero("post_reset");

    // Directed masked-write / bypass table on port 1.
    for (int v = 0; v < 7; v++) begin
      wren = vecs[v].wren; wmask = vecs[v].wmask; waddr = vecs[v].waddr;
      wdata = vecs[v].wdata; rden = 3'b010; ra[1] = vecs[v].raddr1;
      step();
      chk($sformatf("tbl%0d_b", v), if_b.rdata[63:32], vecs[v].exp_b);
      chk($sformatf("tbl%0d_n", v), if_n.rdata[63:32], vecs[v].exp_n);
    end
    idle();

    // Random multi-port traffic with frequent write/read address collisions.
    for (int c = 0; c < 100; c++) begin
      ra[0] = 5'($urandom_range(0, DP - 1));
      ra[1] = 5'((ra[0] + 1 + $urandom_range(0, 9)) % DP);
      ra[2] = 5'((ra[1] + 1 + $urandom_range(0, 9)) % DP);
      rden  = 3'($urandom);
      wren  = 1'($urandom);
      wmask = 4'($urandom);
      wdata = $urandom;
      waddr = ($urandom_range(0, 1) == 1) ? ra[$urandom_range(0, NP - 1)] : 5'($urandom);
      step();
    end
    idle();

    // Clear together with a write and a read: both dropped, full re-sweep.
    clear = 1'b1; wren = 1'b1; wmask = 4'hF; waddr = 5'd7; wdata = 32'h77777777;
    rden = 3'b001; ra[0] = 5'd7;
    step();
    chk("clr_rvalid0", {31'b0, if_b.rvalid[0]}, 32'd0);
    chk("clr_ready", {31'b0, if_b.ready}, 32'd0);
    idle();
    wait_ready(n);
    chk("clr_sweep_len", n, DP);
    read_all_zero("post_clear");

    // Clear asserted mid-sweep restarts the sweep from entry 0.
    clear = 1'b1; step(); idle();
    for (int k = 0; k < 5; k++) step();
    clear = 1'b1; step(); idle();
    wait_ready(n);
    chk("init_clr_len", n, DP);

    // Reset in the middle of a read.
    wren = 1'b1; wmask = 4'hF; waddr = 5'd4; wdata = 32'hCAFEF00D; step(); idle();
    rden = 3'b001; ra[0] = 5'd4; step(); idle();
    chk("pre_rst_rd", if_b.rdata[31:0], 32'hCAFEF00D);
    reset_pulse("rst_read");
    wait_ready(n);
    chk("rst_read_len", n, DP);

    // Reset at sweep cycle 10.
    reset_pulse("rst_a");
    for (int k = 0; k < 10; k++) step();
    reset_pulse("rst_sweep");
    wait_ready(n);
    chk("rst_sweep_len", n, DP);
    read_all_zero("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
